// File: rtl/timebase_decimator_if.sv
// Sample-stream bundle between the ADC reader, the timebase decimator and the capture logic.
interface timebase_decimator_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 3
);
    localparam int PW = 2**SHIFT_WIDTH - 1;

    logic                   in_valid;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [SHIFT_WIDTH-1:0] ratio_log2;
    logic                   avg_en;
    logic                   sync_clear;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [PW-1:0]          window_pos;

    modport master (
        output in_valid, in_data, ratio_log2, avg_en, sync_clear,
        input  out_valid, out_data, window_pos
    );

    modport slave (
        input  in_valid, in_data, ratio_log2, avg_en, sync_clear,
        output out_valid, out_data, window_pos
    );
endinterface

// File: rtl/timebase_decimator.sv
// Power-of-two sample-rate reducer (boxcar average or plain decimation) for the capture path.
// Define DECIM_ROUND_EN for round-half-up averaging; the default build truncates.
module timebase_decimator #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 3,
    parameter int ACC_WIDTH   = DATA_WIDTH + 2**SHIFT_WIDTH - 1
) (
    input logic                 clk_i,
    input logic                 reset_i,
    timebase_decimator_if.slave bus
);
    localparam int PW = 2**SHIFT_WIDTH - 1;

    logic [PW-1:0]          pos_q, pos_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   mode_q, mode_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

    logic                   start;
    logic [SHIFT_WIDTH-1:0] shift_eff;
    logic                   mode_eff;
    logic [PW:0]            cnt_nxt, win_len;
    logic [ACC_WIDTH-1:0]   acc_sum, rnd, acc_shr;

    always_comb begin
        // A sync_clear restarts the window, so this cycle's sample opens a new one.
        start     = bus.sync_clear || (pos_q == '0);
        shift_eff = start ? bus.ratio_log2 : shift_q;
        mode_eff  = start ? bus.avg_en : mode_q;
        cnt_nxt   = {1'b0, (start ? {PW{1'b0}} : pos_q)} + (PW+1)'(1);
        win_len   = (PW+1)'(1) << shift_eff;
        acc_sum   = (start ? {ACC_WIDTH{1'b0}} : acc_q) + ACC_WIDTH'(bus.in_data);
        rnd       = '0;
`ifdef DECIM_ROUND_EN
        if (shift_eff != '0) rnd = ACC_WIDTH'(1) << (shift_eff - SHIFT_WIDTH'(1));
`endif
        acc_shr   = (acc_sum + rnd) >> shift_eff;

        pos_d       = pos_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (bus.sync_clear) begin
            pos_d = '0;
            acc_d = '0;
        end

        if (bus.in_valid) begin
            if (start) begin
                shift_d = bus.ratio_log2;
                mode_d  = bus.avg_en;
            end
            if (cnt_nxt == win_len) begin
                // Final sample of the window: result is the average or this very sample.
                out_valid_d = 1'b1;
                out_data_d  = mode_eff ? acc_shr[DATA_WIDTH-1:0] : bus.in_data;
                pos_d       = '0;
                acc_d       = '0;
            end else begin
                pos_d = cnt_nxt[PW-1:0];
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pos_q       <= '0;
            acc_q       <= '0;
            shift_q     <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            pos_q       <= pos_d;
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.window_pos = pos_q;
endmodule

// File: tb/tb_timebase_decimator.sv
// Directed, table-driven check of timebase_decimator in both averaging and decimation modes.
module tb_timebase_decimator;
`ifdef DECIM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timebase_decimator_if #(.DATA_WIDTH(16), .SHIFT_WIDTH(3)) bus ();

    timebase_decimator #(.DATA_WIDTH(16), .SHIFT_WIDTH(3)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  r;
        logic        a;
        logic [15:0] d;
        logic        sc;
        logic        ev;
        logic [15:0] ed;
        logic [6:0]  ep;
    } vec_t;

    vec_t tv[36];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One sample strobe, check outputs the following cycle, then one idle cycle.
    task automatic step(input logic [2:0] r, input logic a, input logic [15:0] d, input logic sc,
                        input logic ev, input logic [15:0] ed, input logic [6:0] ep, input string nm);
        bus.ratio_log2 = r;
        bus.avg_en     = a;
        bus.in_data    = d;
        bus.sync_clear = sc;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.sync_clear = 1'b0;
        chk({nm, " out_valid"}, int'(bus.out_valid), int'(ev));
        chk({nm, " out_data"}, int'(bus.out_data), int'(ed));
        chk({nm, " window_pos"}, int'(bus.window_pos), int'(ep));
        @(negedge clk);
        chk({nm, " strobe_len"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        logic [15:0] r2, r6;
        r2 = RND ? 16'd2 : 16'd1;
        r6 = RND ? 16'd2 : 16'd1;
        //        r     a     data   sc    ev    ed     ep
        tv[0]  = '{3'd0, 1'b1, 16'd100, 1'b0, 1'b1, 16'd100, 7'd0};
        tv[1]  = '{3'd0, 1'b1, 16'd200, 1'b0, 1'b1, 16'd200, 7'd0};
        tv[2]  = '{3'd0, 1'b1, 16'd300, 1'b0, 1'b1, 16'd300, 7'd0};
        tv[3]  = '{3'd2, 1'b1, 16'd10,  1'b0, 1'b0, 16'd300, 7'd1};
        tv[4]  = '{3'd2, 1'b1, 16'd20,  1'b0, 1'b0, 16'd300, 7'd2};
        tv[5]  = '{3'd2, 1'b1, 16'd30,  1'b0, 1'b0, 16'd300, 7'd3};
        tv[6]  = '{3'd2, 1'b1, 16'd40,  1'b0, 1'b1, 16'd25,  7'd0};
        tv[7]  = '{3'd1, 1'b1, 16'd1,   1'b0, 1'b0, 16'd25,  7'd1};
        tv[8]  = '{3'd1, 1'b1, 16'd2,   1'b0, 1'b1, r2,      7'd0};
        tv[9]  = '{3'd1, 1'b0, 16'd1,   1'b0, 1'b0, r2,      7'd1};
        tv[10] = '{3'd1, 1'b0, 16'd2,   1'b0, 1'b1, 16'd2,   7'd0};
        tv[11] = '{3'd2, 1'b1, 16'd4,   1'b0, 1'b0, 16'd2,   7'd1};
        tv[12] = '{3'd2, 1'b1, 16'd8,   1'b0, 1'b0, 16'd2,   7'd2};
        tv[13] = '{3'd0, 1'b1, 16'd12,  1'b0, 1'b0, 16'd2,   7'd3};
        tv[14] = '{3'd0, 1'b1, 16'd16,  1'b0, 1'b1, 16'd10,  7'd0};
        tv[15] = '{3'd0, 1'b1, 16'd5,   1'b0, 1'b1, 16'd5,   7'd0};
        tv[16] = '{3'd2, 1'b0, 16'd9,   1'b0, 1'b0, 16'd5,   7'd1};
        tv[17] = '{3'd2, 1'b0, 16'd8,   1'b0, 1'b0, 16'd5,   7'd2};
        tv[18] = '{3'd2, 1'b0, 16'd7,   1'b0, 1'b0, 16'd5,   7'd3};
        tv[19] = '{3'd2, 1'b0, 16'd6,   1'b0, 1'b1, 16'd6,   7'd0};
        tv[20] = '{3'd2, 1'b1, 16'd1,   1'b0, 1'b0, 16'd6,   7'd1};
        tv[21] = '{3'd2, 1'b1, 16'd1,   1'b0, 1'b0, 16'd6,   7'd2};
        tv[22] = '{3'd2, 1'b1, 16'd2,   1'b0, 1'b0, 16'd6,   7'd3};
        tv[23] = '{3'd2, 1'b1, 16'd2,   1'b0, 1'b1, r6,      7'd0};
        tv[24] = '{3'd2, 1'b1, 16'd3,   1'b0, 1'b0, r6,      7'd1};
        tv[25] = '{3'd2, 1'b1, 16'd5,   1'b0, 1'b0, r6,      7'd2};
        tv[26] = '{3'd2, 1'b1, 16'd7,   1'b1, 1'b0, r6,      7'd1};
        tv[27] = '{3'd2, 1'b1, 16'd7,   1'b0, 1'b0, r6,      7'd2};
        tv[28] = '{3'd2, 1'b1, 16'd7,   1'b0, 1'b0, r6,      7'd3};
        tv[29] = '{3'd2, 1'b1, 16'd7,   1'b0, 1'b1, 16'd7,   7'd0};
        tv[30] = '{3'd2, 1'b1, 16'd50,  1'b0, 1'b0, 16'd7,   7'd1};
        tv[31] = '{3'd0, 1'b1, 16'd60,  1'b1, 1'b1, 16'd60,  7'd0};
        tv[32] = '{3'd2, 1'b0, 16'd1,   1'b0, 1'b0, 16'd60,  7'd1};
        tv[33] = '{3'd2, 1'b1, 16'd2,   1'b0, 1'b0, 16'd60,  7'd2};
        tv[34] = '{3'd2, 1'b1, 16'd3,   1'b0, 1'b0, 16'd60,  7'd3};
        tv[35] = '{3'd2, 1'b1, 16'd4,   1'b0, 1'b1, 16'd4,   7'd0};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.ratio_log2 = '0;
        bus.avg_en     = 1'b0;
        bus.sync_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_data", int'(bus.out_data), 0);
        chk("reset window_pos", int'(bus.window_pos), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 36; i++)
            step(tv[i].r, tv[i].a, tv[i].d, tv[i].sc, tv[i].ev, tv[i].ed, tv[i].ep,
                 $sformatf("vec%0d", i));

        // sync_clear alone discards a partial window and leaves out_data alone
        step(3'd1, 1'b1, 16'd90, 1'b0, 1'b0, 16'd4, 7'd1, "sclr_part");
        bus.sync_clear = 1'b1;
        @(negedge clk);
        bus.sync_clear = 1'b0;
        chk("sclr_idle out_valid", int'(bus.out_valid), 0);
        chk("sclr_idle window_pos", int'(bus.window_pos), 0);
        chk("sclr_idle out_data", int'(bus.out_data), 4);
        step(3'd1, 1'b1, 16'd6, 1'b0, 1'b0, 16'd4, 7'd1, "sclr_new1");
        step(3'd1, 1'b1, 16'd8, 1'b0, 1'b1, 16'd7, 7'd0, "sclr_new2");

        // back-to-back strobes at N=1
        bus.ratio_log2 = 3'd0;
        bus.avg_en     = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 16'd11;
        @(negedge clk);
        chk("b2b first", int'(bus.out_data), 11);
        chk("b2b first valid", int'(bus.out_valid), 1);
        bus.in_data = 16'd22;
        @(negedge clk);
        chk("b2b second", int'(bus.out_data), 22);
        chk("b2b second valid", int'(bus.out_valid), 1);
        bus.in_data = 16'd33;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b2b third", int'(bus.out_data), 33);
        chk("b2b third valid", int'(bus.out_valid), 1);
        @(negedge clk);

        // N=128 full-scale window
        for (int i = 0; i < 128; i++) begin
            if (i < 127)
                step(3'd7, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'd33, 7'(i + 1), "n128");
            else
                step(3'd7, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 7'd0, "n128_end");
        end

        // reset 50 samples into a fresh window; next window must be a full 128
        for (int i = 0; i < 50; i++)
            step(3'd7, 1'b1, 16'h1000, 1'b0, 1'b0, 16'hFFFF, 7'(i + 1), "pre_rst");
        rst = 1'b1;
        #1;
        chk("midrst out_valid", int'(bus.out_valid), 0);
        chk("midrst out_data", int'(bus.out_data), 0);
        chk("midrst window_pos", int'(bus.window_pos), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            if (i < 127)
                step(3'd7, 1'b1, 16'h0200, 1'b0, 1'b0, 16'd0, 7'(i + 1), "post_rst");
            else
                step(3'd7, 1'b1, 16'h0200, 1'b0, 1'b1, 16'h0200, 7'd0, "post_rst_end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
